// File: rtl/myproject_mul_arb_pkg.sv
// Shared defaults, tag type and width helper for the shared-multiplier arbiter.
package myproject_mul_arb_pkg;

  localparam int unsigned Din0WDef  = 6;
  localparam int unsigned Din1WDef  = 5;
  localparam int unsigned DoutWDef  = 11;
  localparam int unsigned MulLatDef = 4;
  // Widest tag id needed for up to 16 requesters.
  localparam int unsigned MaxIdW    = 4;

  typedef struct packed {
    logic              valid;
    logic [MaxIdW-1:0] id;
  } tag_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/myproject_mul_tag_pipe.sv
// Shift register of {valid, id} tags travelling alongside the multiplier pipeline.
module myproject_mul_tag_pipe
  import myproject_mul_arb_pkg::*;
#(
  parameter int unsigned Depth = MulLatDef
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  tag_t stage_q [Depth];

  // Flush only drops valids; stale ids are harmless behind a cleared valid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i].valid <= 1'b0;
      end
    end else if (en_i) begin
      stage_q[0] <= tag_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/myproject_mul_share_arb.sv
// Round-robin sharing of one pipelined multiplier among NumReq requesters.
// Define MYPROJECT_MUL_ARB_STATS_EN to add issue/stall counter outputs.
module myproject_mul_share_arb
  import myproject_mul_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = clog2(NumReq),
  parameter int unsigned Din0W  = Din0WDef,
  parameter int unsigned Din1W  = Din1WDef,
  parameter int unsigned DoutW  = DoutWDef,
  parameter int unsigned MulLat = MulLatDef
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic                     flush_i,
  input  logic [NumReq-1:0]        req_valid_i,
  output logic [NumReq-1:0]        req_ready_o,
  input  logic [NumReq*Din0W-1:0]  req_a_i,
  input  logic [NumReq*Din1W-1:0]  req_b_i,
  output logic                     mul_ce_o,
  output logic [Din0W-1:0]         mul_din0_o,
  output logic [Din1W-1:0]         mul_din1_o,
  input  logic [DoutW-1:0]         mul_dout_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [IdW-1:0]           rsp_id_o,
  output logic [DoutW-1:0]         rsp_data_o,
  output logic                     idle_o
`ifdef MYPROJECT_MUL_ARB_STATS_EN
  ,
  output logic [31:0]              issue_cnt_o,
  output logic [31:0]              stall_cnt_o
`endif
);

  logic           stall;
  logic           can_issue;
  logic           grant_any;
  logic [IdW-1:0] grant_idx;
  logic [IdW:0]   cand;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic           pipe_busy;
  tag_t           tag_in;
  tag_t           tag_out;

  assign stall     = rsp_valid_o & ~rsp_ready_i;
  assign mul_ce_o  = en_i & ~stall;
  // Reset is folded in so no grant is ever shown while reset is held.
  assign can_issue = mul_ce_o & ~flush_i & ~reset_i;

  // Scan requesters from rr_ptr_q with wrap-around; first hit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdW+1)'(k);
      if (cand >= (IdW+1)'(NumReq)) begin
        cand = cand - (IdW+1)'(NumReq);
      end
      if (!grant_any && req_valid_i[cand[IdW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[IdW-1:0];
      end
    end
    if (!can_issue) begin
      grant_any = 1'b0;
    end
  end

  always_comb begin
    req_ready_o = '0;
    mul_din0_o  = '0;
    mul_din1_o  = '0;
    rr_ptr_d    = rr_ptr_q;
    tag_in      = '0;
    if (grant_any) begin
      req_ready_o[grant_idx] = 1'b1;
      mul_din0_o = req_a_i[grant_idx*Din0W +: Din0W];
      mul_din1_o = req_b_i[grant_idx*Din1W +: Din1W];
      rr_ptr_d   = (grant_idx == IdW'(NumReq-1)) ? '0 : grant_idx + 1'b1;
      tag_in.valid = 1'b1;
      tag_in.id    = MaxIdW'(grant_idx);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  myproject_mul_tag_pipe #(
    .Depth (MulLat)
  ) u_tag_pipe (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (mul_ce_o),
    .flush_i (flush_i),
    .tag_i   (tag_in),
    .tag_o   (tag_out),
    .busy_o  (pipe_busy)
  );

  // Product passes straight through; the multiplier holds it while ce is low.
  assign rsp_valid_o = tag_out.valid;
  assign rsp_id_o    = IdW'(tag_out.id);
  assign rsp_data_o  = mul_dout_i;
  assign idle_o      = ~pipe_busy & ~(|req_valid_i);

`ifdef MYPROJECT_MUL_ARB_STATS_EN
  logic [31:0] issue_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_any) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign issue_cnt_o = issue_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Bench for myproject_mul_share_arb: external multiplier model, queue-based reference, directed tests.
module tb_myproject_mul_share_arb;

  localparam int NR  = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          flush;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [23:0]   req_a;
  logic [19:0]   req_b;
  logic          mul_ce;
  logic [5:0]    mul_din0;
  logic [4:0]    mul_din1;
  logic [10:0]   mul_dout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [10:0]   rsp_data;
  logic          idle;
`ifdef MYPROJECT_MUL_ARB_STATS_EN
  logic [31:0]   issue_cnt;
  logic [31:0]   stall_cnt;
`endif

  myproject_mul_share_arb dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .en_i        (en),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .mul_ce_o    (mul_ce),
    .mul_din0_o  (mul_din0),
    .mul_din1_o  (mul_din1),
    .mul_dout_i  (mul_dout),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .idle_o      (idle)
`ifdef MYPROJECT_MUL_ARB_STATS_EN
    ,
    .issue_cnt_o (issue_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // External multiplier: input register plus three product stages, clock-enabled.
  logic [5:0]         ma;
  logic signed [4:0]  mb;
  logic signed [10:0] p1, p2, p3;
  always @(posedge clk) begin
    if (mul_ce) begin
      ma <= mul_din0;
      mb <= mul_din1;
      p1 <= $signed({1'b0, ma}) * mb;
      p2 <= p1;
      p3 <= p2;
    end
  end
  assign mul_dout = p3;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Requester state owned by the stimulus process.
  int a_val [NR];
  int b_val [NR];
  int rem   [NR];
  logic [3:0] gnt_seen = 4'b0;

  typedef struct { int id; int prod; int age; } fl_t;
  typedef struct { int id; int data; int cyc; } rsp_t;
  fl_t  q[$];
  rsp_t rsp_log[$];
  int   gnt_log[$];
  int   gnt_cyc[$];
  int   cyc = 0;
  int   ce_low = 0;
  int   rr = 0;

  int         e_g;
  bit         e_rv, e_ce;
  logic [5:0] e_a;
  logic [4:0] e_b;

  // Reference model: in-flight items age by one per enabled edge and emerge at age LAT.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      rr = 0;
    end
    e_rv = (q.size() > 0) && (q[0].age == LAT);
    e_ce = en && !(e_rv && !rsp_ready);
    e_g  = -1;
    if (e_ce && !flush && !reset) begin
      for (int k = 0; k < NR; k++) begin
        if (e_g < 0 && req_valid[(rr + k) % NR]) e_g = (rr + k) % NR;
      end
    end
    e_a = (e_g >= 0) ? a_val[e_g][5:0] : 6'd0;
    e_b = (e_g >= 0) ? b_val[e_g][4:0] : 5'd0;
    chk("req_ready", int'(req_ready), (e_g >= 0) ? (1 << e_g) : 0);
    chk("mul_ce", int'(mul_ce), int'(e_ce));
    chk("mul_din0", int'(mul_din0), int'(e_a));
    chk("mul_din1", int'(mul_din1), int'(e_b));
    chk("rsp_valid", int'(rsp_valid), int'(e_rv));
    if (e_rv) begin
      chk("rsp_id", int'(rsp_id), q[0].id);
      chk("rsp_data", int'($signed(rsp_data)), q[0].prod);
    end
    chk("idle", int'(idle), int'(q.size() == 0 && req_valid == 4'b0));

    gnt_seen = req_ready;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i]) begin
        gnt_log.push_back(i);
        gnt_cyc.push_back(cyc);
      end
    end
    if (rsp_valid && rsp_ready && en)
      rsp_log.push_back('{int'(rsp_id), int'($signed(rsp_data)), cyc});
    if (!mul_ce) ce_low++;

    if (!reset) begin
      if (flush) begin
        q.delete();
      end else if (e_ce) begin
        if (e_rv) void'(q.pop_front());
        foreach (q[j]) q[j].age++;
        if (e_g >= 0) begin
          q.push_back('{e_g, a_val[e_g] * b_val[e_g], 1});
          rr = (e_g + 1) % NR;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_a[i*6 +: 6] = a_val[i][5:0];
      req_b[i*5 +: 5] = b_val[i][4:0];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (gnt_seen[i] && rem[i] > 0) rem[i]--;
    end
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) rem[i] = 0;
    drive();
    step();
    step();
    reset = 1'b0;
    rsp_log.delete();
    gnt_log.delete();
    gnt_cyc.delete();
    ce_low = 0;
  endtask

  function automatic int gid(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : -999;
  endfunction
  function automatic int gcy(input int k);
    return (k < gnt_cyc.size()) ? gnt_cyc[k] : -999;
  endfunction
  function automatic int rid(input int k);
    return (k < rsp_log.size()) ? rsp_log[k].id : -999;
  endfunction
  function automatic int rdat(input int k);
    return (k < rsp_log.size()) ? rsp_log[k].data : -9999;
  endfunction
  function automatic int rcy(input int k);
    return (k < rsp_log.size()) ? rsp_log[k].cyc : -999;
  endfunction

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < NR; i++) begin
      a_val[i] = 0; b_val[i] = 0; rem[i] = 0;
    end
    drive();
    #1;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_idle", int'(idle), 1);
    do_reset();

    // Single request from requester 2: 63 * -16.
    a_val[2] = 63; b_val[2] = -16; rem[2] = 1; drive();
    repeat (8) step();
    chk("t1_ngnt", gnt_log.size(), 1);
    chk("t1_gnt", gid(0), 2);
    chk("t1_nrsp", rsp_log.size(), 1);
    chk("t1_id", rid(0), 2);
    chk("t1_data", rdat(0), -1008);
    chk("t1_lat", rcy(0) - gcy(0), 4);

    // All four requesters, two requests each.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a_val[i] = i + 1; b_val[i] = 3; rem[i] = 2;
    end
    drive();
    repeat (14) step();
    chk("t2_nrsp", rsp_log.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t2_gnt", gid(k), k % 4);
      chk("t2_id", rid(k), k % 4);
      chk("t2_data", rdat(k), 3 * ((k % 4) + 1));
    end

    // Backpressure for five cycles with a full pipe.
    do_reset();
    rsp_ready = 1'b0;
    rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1; drive();
    repeat (9) step();
    chk("t3_ce_low", ce_low, 5);
    chk("t3_nrsp_stalled", rsp_log.size(), 0);
    rsp_ready = 1'b1;
    repeat (8) step();
    chk("t3_nrsp", rsp_log.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk("t3_id", rid(k), k % 4);
      chk("t3_data", rdat(k), 3 * ((k % 4) + 1));
      chk("t3_b2b", rcy(k) - rcy(0), k);
    end
    chk("t3_regrant", gcy(4) - gcy(0), 9);

    // Three streamed requests, then flush.
    do_reset();
    rem[0] = 1; rem[1] = 1; rem[2] = 1; drive();
    repeat (3) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (6) step();
    chk("t4_flushed", rsp_log.size(), 0);
    a_val[3] = 5; b_val[3] = -7; rem[3] = 1; drive();
    repeat (7) step();
    chk("t4_nrsp", rsp_log.size(), 1);
    chk("t4_id", rid(0), 3);
    chk("t4_data", rdat(0), -35);

    // Boundary operands with a two-cycle enable gap.
    do_reset();
    a_val[0] = 0;  b_val[0] = -16; rem[0] = 1;
    a_val[1] = 63; b_val[1] = 15;  rem[1] = 1;
    a_val[2] = 10; b_val[2] = -1;  rem[2] = 1;
    drive();
    repeat (2) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (10) step();
    chk("t5_nrsp", rsp_log.size(), 3);
    chk("t5_d0", rdat(0), 0);
    chk("t5_d1", rdat(1), 945);
    chk("t5_d2", rdat(2), -10);
    chk("t5_id2", rid(2), 2);
    chk("t5_lat0", rcy(0) - gcy(0), 6);
    chk("t5_lat1", rcy(1) - gcy(1), 6);
    chk("t5_lat2", rcy(2) - gcy(2), 4);

    // Asynchronous reset in the middle of a stream.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a_val[i] = i + 1; b_val[i] = 3; rem[i] = 3;
    end
    drive();
    repeat (6) step();
    chk("t6_pre_rv", int'(rsp_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rv", int'(rsp_valid), 0);
    chk("t6_rdy", int'(req_ready), 0);
    rsp_log.delete();
    step();
    for (int i = 0; i < NR; i++) rem[i] = 0;
    drive();
    reset = 1'b0;
    repeat (8) step();
    chk("t6_idle", int'(idle), 1);
    chk("t6_nrsp", rsp_log.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/myproject_mul_share_arb.md
Name: myproject_mul_share_arb

Overview:
- Round-robin arbiter/sequencer sharing one pipelined 6-bit-unsigned x 5-bit-signed multiplier (11-bit signed product) among NUM_REQ requesters.
- Issues at most one operand pair per cycle and drives the multiplier clock-enable.
- Carries a requester tag and valid bit alongside the multiplier pipeline.
- Returns each product with its tag on a single valid/ready response port; backpressure freezes the whole pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, 2, tag width, equals clog2(NUM_REQ)
- DIN0_W, 6, operand A width, unsigned
- DIN1_W, 5, operand B width, two's complement
- DOUT_W, 11, product width, signed
- MUL_LAT, 4, multiplier latency in enabled cycles: input register plus three product stages

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- en  in  1  global enable; 0 freezes issue and pipeline
- flush  in  1  synchronous; discards all in-flight tags
- req_valid  in  NUM_REQ  per-requester request
- req_ready  out  NUM_REQ  one-hot grant; asserted only when that req_valid is high
- req_a  in  NUM_REQ*DIN0_W  packed operand A, requester i at bits [i*DIN0_W +: DIN0_W]
- req_b  in  NUM_REQ*DIN1_W  packed operand B, same packing
- mul_ce  out  1  multiplier clock-enable
- mul_din0  out  DIN0_W  operand A to multiplier
- mul_din1  out  DIN1_W  operand B to multiplier
- mul_dout  in  DOUT_W  multiplier product
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  ID_W  requester index of response
- rsp_data  out  DOUT_W  signed product
- idle  out  1  no tag in flight and no req_valid asserted

Behaviour:
- Reset: tag-pipe valids = 0, rr_ptr = 0, rsp_valid = 0, req_ready = 0. idle = 1 once req_valid = 0. Multiplier datapath is not reset; garbage is masked by the tag valids.
- stall = rsp_valid & ~rsp_ready. mul_ce = en & ~stall, combinational.
- Arbitration is combinational. Scan req_valid starting at rr_ptr with wrap-around. The first set bit i gets grant; it is granted only if mul_ce = 1.
- On grant:
  - req_ready[i] = 1; mul_din0/mul_din1 = req_a[i]/req_b[i].
  - rr_ptr <= (i+1) mod NUM_REQ on the clock edge.
  - With no grant, rr_ptr holds.
- mul_din0/din1 when there is no grant: 0.
- Tag pipe: MUL_LAT stages of {valid, id}. Advances only when mul_ce = 1. Stage 0 loads {grant_any, i}.
- rsp_valid = last-stage valid; rsp_id = last-stage id; rsp_data = mul_dout, passed straight through. mul_dout is stable while ce = 0, so rsp_data is held during a stall.
- Throughput: 1 result/cycle with rsp_ready = 1 and en = 1. Latency from grant to rsp_valid = MUL_LAT cycles.
- Stall: rsp_valid & ~rsp_ready freezes everything. No grant, no tag motion, and the response holds stable until accepted.
- en = 0 freezes everything, including the response. rsp_valid stays as it was.
- flush = 1:
  - All tag valids clear next cycle and no grant is issued this cycle.
  - rr_ptr is unchanged.
  - flush has priority over stall.
- Reset mid-operation: in-flight products are lost and no response is emitted for them.
- req_valid dropped without a grant: no effect. Requesters must hold operands stable while req_valid = 1.

Optional Feature:
- Macro: MYPROJECT_MUL_ARB_STATS_EN.
- When defined, adds two output ports:
  - issue_cnt (32 bits): counts grants.
  - stall_cnt (32 bits): counts cycles with stall = 1.
- Both counters are cleared by reset and wrap at 2^32.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package myproject_mul_arb_pkg holds: the DIN0_W/DIN1_W/DOUT_W/MUL_LAT defaults, the ID_W clog2 function, and the tag struct typedef {valid, id}.
- One sub-module, myproject_mul_tag_pipe: a MUL_LAT-deep {valid, id} shift register with enable, flush and async reset.
- The round-robin picker stays inline.

Test Plan:
- Reset, then a single request from requester 2 with a=63, b=-16 -> grant the same cycle; 4 cycles later rsp_valid=1, rsp_id=2, rsp_data=-1008 (11'h410).
- All 4 requesters hold valid for 8 cycles (a=i+1, b=3) -> grant order 0,1,2,3,0,1,2,3; responses in the same order with data 3,6,9,12 repeated.
- rsp_ready=0 for 5 cycles with the pipe full -> mul_ce=0, req_ready=0, rsp_id/rsp_data stable. After release, the 4 queued responses drain back-to-back.
- Back-to-back streaming of 3 requests followed by flush in the next cycle -> no rsp_valid ever appears for those 3. A request issued after the flush responds normally.
- Boundary values a=0, b=-16 -> 0; a=63, b=15 -> 945. Toggle en=0 for 2 cycles mid-stream -> latency extends by exactly 2 cycles and no result is lost or duplicated.
- Async reset asserted mid-stream -> rsp_valid=0 and req_ready=0 immediately; idle=1 after release with no requests pending.
